// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_parser_if
// Purpose : Bundles the UART byte streams and the register bus that surround
//           the command parser.
//           master modport : the parser (drives o_* signals)
//           slave  modport : the surroundings (UART RX/TX and register file)
// Ports   : i_rx_dv/i_rx_byte   received byte strobe and value
//           o_tx_dv/o_tx_byte   byte to send, i_tx_done transmitter finished
//           o_reg_wr/o_reg_rd   single-cycle register strobes
//           o_reg_addr/o_reg_wdata/i_reg_rdata  register address and data
//           o_busy/o_err/o_overrun  status
// Revision: 1.0 - initial release
// ============================================================================
interface uart_cmd_parser_if;
    logic       i_rx_dv;
    logic [7:0] i_rx_byte;
    logic       o_tx_dv;
    logic [7:0] o_tx_byte;
    logic       i_tx_done;
    logic       o_reg_wr;
    logic       o_reg_rd;
    logic [7:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic [7:0] i_reg_rdata;
    logic       o_busy;
    logic       o_err;
    logic       o_overrun;

    modport master (
        input  i_rx_dv, i_rx_byte, i_tx_done, i_reg_rdata,
        output o_tx_dv, o_tx_byte, o_reg_wr, o_reg_rd, o_reg_addr,
               o_reg_wdata, o_busy, o_err, o_overrun
    );

    modport slave (
        output i_rx_dv, i_rx_byte, i_tx_done, i_reg_rdata,
        input  o_tx_dv, o_tx_byte, o_reg_wr, o_reg_rd, o_reg_addr,
               o_reg_wdata, o_busy, o_err, o_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_parser
// Purpose : Frames ASCII hex commands "Waadd\n" / "Raa\n" from the UART
//           receiver, issues register read/write strobes and streams the
//           reply ("K\n", "hh\n" or "E\n") into the UART transmitter.
// Ports   : clk      system clock, all logic on posedge
//           rst      synchronous active-high reset
//           cmd_bus  uart_cmd_parser_if.master (UART streams, register bus,
//                    busy/err/overrun status)
// Params  : WR_ACK      1 = write replies "K\n", 0 = silent write
//           RD_LATENCY  cycles from o_reg_rd to the read-data sample (1..15)
// Revision: 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter int WR_ACK     = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_parser_if.master cmd_bus
);

    localparam logic [7:0] c_LF     = 8'h0A;
    localparam logic [7:0] c_CR     = 8'h0D;
    localparam logic [7:0] c_K      = 8'h4B;
    localparam logic [7:0] c_E      = 8'h45;
    localparam logic [3:0] c_RD_LAT = RD_LATENCY[3:0];

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR_HI  = 4'd1,
        S_ADDR_LO  = 4'd2,
        S_DATA_HI  = 4'd3,
        S_DATA_LO  = 4'd4,
        S_EOL      = 4'd5,
        S_FLUSH    = 4'd6,
        S_EXEC     = 4'd7,
        S_RD_WAIT  = 4'd8,
        S_ERR_RESP = 4'd9,
        S_SEND     = 4'd10,
        S_TX_WAIT  = 4'd11
    } state_t;

    // {valid, nibble}; letters map via low nibble + 9 ('A'/'a' -> 1 + 9 = 10)
    function automatic logic [4:0] hex_dec(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39)
            return {1'b1, b[3:0]};
        else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            return {1'b1, b[3:0] + 4'd9};
        else
            return 5'd0;
    endfunction

    function automatic logic [7:0] hex_enc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    state_t     r_state;
    state_t     w_next;
    logic       r_wr_flag;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [3:0] r_lat_cnt;
    logic [7:0] r_buf0, r_buf1, r_buf2;
    logic [1:0] r_len;
    logic [1:0] r_idx;

    logic       w_busy, w_tx_dv, w_reg_wr, w_reg_rd, w_err;
    logic [4:0] w_dec;
    logic       w_hex_ok;
    logic [3:0] w_nib;
    logic       w_rx_act;
    logic       w_is_lf, w_is_w, w_is_r;
    logic       w_last;
    logic [7:0] w_tx_byte;

    assign w_dec    = hex_dec(cmd_bus.i_rx_byte);
    assign w_hex_ok = w_dec[4];
    assign w_nib    = w_dec[3:0];
    // CR is transparent in every receive state
    assign w_rx_act = cmd_bus.i_rx_dv && (cmd_bus.i_rx_byte != c_CR);
    assign w_is_lf  = (cmd_bus.i_rx_byte == c_LF);
    assign w_is_w   = (cmd_bus.i_rx_byte == 8'h57) || (cmd_bus.i_rx_byte == 8'h77);
    assign w_is_r   = (cmd_bus.i_rx_byte == 8'h52) || (cmd_bus.i_rx_byte == 8'h72);
    assign w_last   = (r_idx == r_len - 2'd1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_tx_dv  = 1'b0;
        w_reg_wr = 1'b0;
        w_reg_rd = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_act) begin
                    if (w_is_w || w_is_r) w_next = S_ADDR_HI;
                    else if (!w_is_lf)    w_next = S_FLUSH;
                end
            end
            S_ADDR_HI: if (w_rx_act) w_next = w_is_lf ? S_ERR_RESP : (w_hex_ok ? S_ADDR_LO : S_FLUSH);
            S_ADDR_LO: if (w_rx_act) w_next = w_is_lf ? S_ERR_RESP :
                                              (w_hex_ok ? (r_wr_flag ? S_DATA_HI : S_EOL) : S_FLUSH);
            S_DATA_HI: if (w_rx_act) w_next = w_is_lf ? S_ERR_RESP : (w_hex_ok ? S_DATA_LO : S_FLUSH);
            S_DATA_LO: if (w_rx_act) w_next = w_is_lf ? S_ERR_RESP : (w_hex_ok ? S_EOL : S_FLUSH);
            S_EOL:     if (w_rx_act) w_next = w_is_lf ? S_EXEC : S_FLUSH;
            S_FLUSH:   if (w_rx_act && w_is_lf) w_next = S_ERR_RESP;
            S_EXEC: begin
                w_busy = 1'b1;
                if (r_wr_flag) begin
                    w_reg_wr = 1'b1;
                    w_next   = (WR_ACK != 0) ? S_SEND : S_IDLE;
                end else begin
                    w_reg_rd = 1'b1;
                    w_next   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                w_busy = 1'b1;
                if (r_lat_cnt == c_RD_LAT) w_next = S_SEND;
            end
            S_ERR_RESP: begin
                w_busy = 1'b1;
                w_err  = 1'b1;
                w_next = S_SEND;
            end
            S_SEND: begin
                w_busy  = 1'b1;
                w_tx_dv = 1'b1;
                w_next  = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                w_busy = 1'b1;
                if (cmd_bus.i_tx_done) w_next = w_last ? S_IDLE : S_SEND;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: address/data shift registers, read-latency counter, reply buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_flag <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_lat_cnt <= 4'd0;
            r_buf0    <= 8'h00;
            r_buf1    <= 8'h00;
            r_buf2    <= 8'h00;
            r_len     <= 2'd0;
            r_idx     <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE:
                    if (w_rx_act && (w_is_w || w_is_r)) r_wr_flag <= w_is_w;
                S_ADDR_HI, S_ADDR_LO:
                    if (w_rx_act && w_hex_ok) r_addr <= {r_addr[3:0], w_nib};
                S_DATA_HI, S_DATA_LO:
                    if (w_rx_act && w_hex_ok) r_wdata <= {r_wdata[3:0], w_nib};
                S_EXEC: begin
                    if (r_wr_flag) begin
                        r_buf0 <= c_K;
                        r_buf1 <= c_LF;
                        r_len  <= 2'd2;
                        r_idx  <= 2'd0;
                    end else begin
                        // counts cycles since the o_reg_rd cycle
                        r_lat_cnt <= 4'd1;
                    end
                end
                S_RD_WAIT: begin
                    if (r_lat_cnt == c_RD_LAT) begin
                        r_buf0 <= hex_enc(cmd_bus.i_reg_rdata[7:4]);
                        r_buf1 <= hex_enc(cmd_bus.i_reg_rdata[3:0]);
                        r_buf2 <= c_LF;
                        r_len  <= 2'd3;
                        r_idx  <= 2'd0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 4'd1;
                    end
                end
                S_ERR_RESP: begin
                    r_buf0 <= c_E;
                    r_buf1 <= c_LF;
                    r_len  <= 2'd2;
                    r_idx  <= 2'd0;
                end
                S_TX_WAIT:
                    if (cmd_bus.i_tx_done && !w_last) r_idx <= r_idx + 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_tx_byte = r_buf2;
        case (r_idx)
            2'd0:    w_tx_byte = r_buf0;
            2'd1:    w_tx_byte = r_buf1;
            default: w_tx_byte = r_buf2;
        endcase
    end

    assign cmd_bus.o_tx_dv     = w_tx_dv;
    assign cmd_bus.o_tx_byte   = w_tx_byte;
    assign cmd_bus.o_reg_wr    = w_reg_wr;
    assign cmd_bus.o_reg_rd    = w_reg_rd;
    assign cmd_bus.o_reg_addr  = r_addr;
    assign cmd_bus.o_reg_wdata = r_wdata;
    assign cmd_bus.o_busy      = w_busy;
    assign cmd_bus.o_err       = w_err;
    // bytes arriving while busy are dropped, never queued
    assign cmd_bus.o_overrun   = w_busy & cmd_bus.i_rx_dv;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_cmd_parser
// Purpose : Directed self-checking bench. dut0 runs WR_ACK=1/RD_LATENCY=3,
//           dut1 runs WR_ACK=0/RD_LATENCY=1. A per-DUT monitor records
//           strobes and transmitted bytes and models the transmitter and the
//           register file read latency.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    localparam int TX_DELAY = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_parser_if bus0 ();
    uart_cmd_parser_if bus1 ();

    uart_cmd_parser #(.WR_ACK(1), .RD_LATENCY(3)) dut0 (.clk(clk), .rst(rst), .cmd_bus(bus0));
    uart_cmd_parser #(.WR_ACK(0), .RD_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .cmd_bus(bus1));

    int total = 0;
    int bad   = 0;

    // dut0 monitor / environment state
    logic [7:0] txq0[$];
    int         txgap0[$];
    int  mcyc0 = 0, last_done0 = 0, fall_cyc0 = 0, done_cnt0 = 0, rd_age0 = 0;
    int  wr_n0 = 0, rd_n0 = 0, err_n0 = 0, ovr_n0 = 0, busy_n0 = 0, hold_bad0 = 0;
    logic [7:0] wr_addr0 = 8'h00, wr_data0 = 8'h00, rd_addr0 = 8'h00, held0 = 8'h00;
    logic [7:0] rd_val0 = 8'h00, rdata0 = 8'hEE;
    logic holding0 = 1'b0, prev_busy0 = 1'b0, auto_done0 = 1'b0;
    logic force_done0 = 1'b0, tx_auto0 = 1'b1;

    assign bus0.i_tx_done   = auto_done0 | force_done0;
    assign bus0.i_reg_rdata = rdata0;

    // dut1 monitor state
    int wr_n1 = 0, txdv_n1 = 0, busy_n1 = 0;
    logic [7:0] wr_addr1 = 8'h00, wr_data1 = 8'h00;

    assign bus1.i_tx_done   = 1'b0;
    assign bus1.i_reg_rdata = 8'h00;

    always @(negedge clk) begin
        auto_done0 = 1'b0;
        if (done_cnt0 > 0) begin
            done_cnt0--;
            if (done_cnt0 == 0) auto_done0 = 1'b1;
        end
        #2;
        mcyc0++;
        if (rst) begin
            holding0  = 1'b0;
            done_cnt0 = 0;
        end else if (holding0 && bus0.o_tx_byte !== held0) begin
            hold_bad0++;
        end
        if (bus0.i_tx_done && holding0) begin
            last_done0 = mcyc0;
            holding0   = 1'b0;
        end
        if (bus0.o_tx_dv) begin
            txq0.push_back(bus0.o_tx_byte);
            txgap0.push_back(mcyc0 - last_done0);
            held0    = bus0.o_tx_byte;
            holding0 = 1'b1;
            if (tx_auto0) done_cnt0 = TX_DELAY;
        end
        if (prev_busy0 && !bus0.o_busy) fall_cyc0 = mcyc0;
        prev_busy0 = bus0.o_busy;
        if (bus0.o_busy)    busy_n0++;
        if (bus0.o_err)     err_n0++;
        if (bus0.o_overrun) ovr_n0++;
        if (bus0.o_reg_wr) begin
            wr_n0++;
            wr_addr0 = bus0.o_reg_addr;
            wr_data0 = bus0.o_reg_wdata;
        end
        // read data is valid only on the cycle RD_LATENCY(3) after o_reg_rd
        if (bus0.o_reg_rd) begin
            rd_n0++;
            rd_addr0 = bus0.o_reg_addr;
            rd_age0  = 1;
        end else if (rd_age0 != 0 && rd_age0 < 100) begin
            rd_age0++;
        end
        rdata0 = (rd_age0 == 4) ? rd_val0 : 8'hEE;
    end

    always @(negedge clk) begin
        #2;
        if (bus1.o_reg_wr) begin
            wr_n1++;
            wr_addr1 = bus1.o_reg_addr;
            wr_data1 = bus1.o_reg_wdata;
        end
        if (bus1.o_tx_dv) txdv_n1++;
        if (bus1.o_busy)  busy_n1++;
    end

    function automatic logic [7:0] q0(input int i);
        return (i < txq0.size()) ? txq0[i] : 8'hxx;
    endfunction

    function automatic int g0(input int i);
        return (i < txgap0.size()) ? txgap0[i] : -1;
    endfunction

    task automatic send_byte(input int sel, input logic [7:0] b);
        @(negedge clk);
        if (sel == 0) begin bus0.i_rx_dv = 1'b1; bus0.i_rx_byte = b; end
        else          begin bus1.i_rx_dv = 1'b1; bus1.i_rx_byte = b; end
        @(negedge clk);
        if (sel == 0) bus0.i_rx_dv = 1'b0;
        else          bus1.i_rx_dv = 1'b0;
    endtask

    task automatic send_str(input int sel, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
    endtask

    // call at a falling edge; returns once dut0 is no longer busy
    task automatic wait_quiet0();
        int n = 0;
        #3;
        while (bus0.o_busy !== 1'b0 && n < 300) begin @(negedge clk); #3; n++; end
        total++;
        if (n >= 300) begin bad++; $display("FAIL wait_idle: o_busy still %b after %0d cycles, required 0", bus0.o_busy, n); end
        @(negedge clk);
    endtask

    // call at a falling edge; returns 3 time units into the o_tx_dv cycle
    task automatic wait_txdv0();
        int n = 0;
        #3;
        while (bus0.o_tx_dv !== 1'b1 && n < 200) begin @(negedge clk); #3; n++; end
        total++;
        if (n >= 200) begin bad++; $display("FAIL wait_tx_dv: o_tx_dv=%b after %0d cycles, required 1", bus0.o_tx_dv, n); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.i_rx_dv = 1'b0; bus0.i_rx_byte = 8'h00;
        bus1.i_rx_dv = 1'b0; bus1.i_rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        total++; if ({bus0.o_tx_dv, bus0.o_reg_wr, bus0.o_reg_rd, bus0.o_busy, bus0.o_err, bus0.o_overrun} !== 6'b0) begin bad++; $display("FAIL reset_ctrl0: got %b expected 000000", {bus0.o_tx_dv, bus0.o_reg_wr, bus0.o_reg_rd, bus0.o_busy, bus0.o_err, bus0.o_overrun}); end
        total++; if (bus0.o_tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte0: got %h expected 00", bus0.o_tx_byte); end
        total++; if (bus0.o_reg_addr !== 8'h00) begin bad++; $display("FAIL reset_addr0: got %h expected 00", bus0.o_reg_addr); end
        total++; if (bus0.o_reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata0: got %h expected 00", bus0.o_reg_wdata); end
        total++; if ({bus1.o_tx_dv, bus1.o_reg_wr, bus1.o_reg_rd, bus1.o_busy, bus1.o_err, bus1.o_overrun} !== 6'b0) begin bad++; $display("FAIL reset_ctrl1: got %b expected 000000", {bus1.o_tx_dv, bus1.o_reg_wr, bus1.o_reg_rd, bus1.o_busy, bus1.o_err, bus1.o_overrun}); end
        total++; if ({bus1.o_reg_addr, bus1.o_reg_wdata, bus1.o_tx_byte} !== 24'h0) begin bad++; $display("FAIL reset_regs1: got %h expected 000000", {bus1.o_reg_addr, bus1.o_reg_wdata, bus1.o_tx_byte}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_ack();
        int b = txq0.size();
        int w = wr_n0;
        int e = err_n0;
        send_str(0, "W1A5F\n");
        wait_quiet0();
        total++; if (wr_n0 - w != 1) begin bad++; $display("FAIL wr_count: got %0d expected 1", wr_n0 - w); end
        total++; if (wr_addr0 !== 8'h1A) begin bad++; $display("FAIL wr_addr: got %h expected 1a", wr_addr0); end
        total++; if (wr_data0 !== 8'h5F) begin bad++; $display("FAIL wr_data: got %h expected 5f", wr_data0); end
        total++; if (txq0.size() - b != 2) begin bad++; $display("FAIL wr_tx_len: got %0d expected 2", txq0.size() - b); end
        total++; if ({q0(b), q0(b + 1)} !== 16'h4B0A) begin bad++; $display("FAIL wr_tx_bytes: got %h expected 4b0a", {q0(b), q0(b + 1)}); end
        total++; if (g0(b + 1) != 1) begin bad++; $display("FAIL wr_tx_gap: got %0d expected 1", g0(b + 1)); end
        total++; if (fall_cyc0 != last_done0 + 1) begin bad++; $display("FAIL wr_busy_drop: got cycle %0d expected %0d", fall_cyc0, last_done0 + 1); end
        total++; if (err_n0 != e) begin bad++; $display("FAIL wr_no_err: got %0d expected %0d", err_n0, e); end
        total++; if (hold_bad0 != 0) begin bad++; $display("FAIL tx_byte_hold: got %0d changes expected 0", hold_bad0); end
    endtask

    task automatic test_read();
        int b = txq0.size();
        int r = rd_n0;
        int w = wr_n0;
        rd_val0 = 8'hA7;
        send_str(0, "r0c\015\n");
        wait_quiet0();
        total++; if (rd_n0 - r != 1) begin bad++; $display("FAIL rd_count: got %0d expected 1", rd_n0 - r); end
        total++; if (rd_addr0 !== 8'h0C) begin bad++; $display("FAIL rd_addr: got %h expected 0c", rd_addr0); end
        total++; if (wr_n0 != w) begin bad++; $display("FAIL rd_no_wr: got %0d expected %0d", wr_n0, w); end
        total++; if (txq0.size() - b != 3) begin bad++; $display("FAIL rd_tx_len: got %0d expected 3", txq0.size() - b); end
        total++; if ({q0(b), q0(b + 1), q0(b + 2)} !== 24'h41370A) begin bad++; $display("FAIL rd_tx_bytes: got %h expected 41370a", {q0(b), q0(b + 1), q0(b + 2)}); end
        total++; if (g0(b + 2) != 1) begin bad++; $display("FAIL rd_tx_gap: got %0d expected 1", g0(b + 2)); end
    endtask

    task automatic test_malformed();
        string frames[3] = '{"W1G\n", "R1\n", "X\n"};
        int b, e, w, r, bz;
        for (int i = 0; i < 3; i++) begin
            b = txq0.size(); e = err_n0; w = wr_n0; r = rd_n0;
            send_str(0, frames[i]);
            wait_quiet0();
            total++; if (err_n0 - e != 1) begin bad++; $display("FAIL bad_frame%0d_err: got %0d expected 1", i, err_n0 - e); end
            total++; if ((wr_n0 - w) + (rd_n0 - r) != 0) begin bad++; $display("FAIL bad_frame%0d_strobe: got %0d expected 0", i, (wr_n0 - w) + (rd_n0 - r)); end
            total++; if (txq0.size() - b != 2 || {q0(b), q0(b + 1)} !== 16'h450A) begin bad++; $display("FAIL bad_frame%0d_tx: got %0d bytes %h expected 2 bytes 450a", i, txq0.size() - b, {q0(b), q0(b + 1)}); end
        end
        b = txq0.size(); e = err_n0; bz = busy_n0;
        send_byte(0, 8'h0A);
        repeat (4) @(negedge clk);
        total++; if (busy_n0 != bz || txq0.size() != b || err_n0 != e) begin bad++; $display("FAIL empty_line: got busy=%0d tx=%0d err=%0d expected 0 0 0", busy_n0 - bz, txq0.size() - b, err_n0 - e); end
    endtask

    task automatic test_overrun();
        int b = txq0.size();
        int o = ovr_n0;
        int w;
        rd_val0 = 8'h5B;
        send_str(0, "R00\n");
        wait_txdv0();
        @(negedge clk);
        bus0.i_rx_dv = 1'b1; bus0.i_rx_byte = 8'h57;
        #1;
        total++; if (bus0.o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b expected 1", bus0.o_overrun); end
        @(negedge clk);
        bus0.i_rx_dv = 1'b0;
        wait_quiet0();
        total++; if (ovr_n0 - o != 1) begin bad++; $display("FAIL ovr_count: got %0d expected 1", ovr_n0 - o); end
        total++; if (txq0.size() - b != 3 || {q0(b), q0(b + 1), q0(b + 2)} !== 24'h35420A) begin bad++; $display("FAIL ovr_tx: got %0d bytes %h expected 3 bytes 35420a", txq0.size() - b, {q0(b), q0(b + 1), q0(b + 2)}); end
        b = txq0.size(); w = wr_n0;
        send_str(0, "W3C9D\n");
        wait_quiet0();
        total++; if (wr_n0 - w != 1 || {wr_addr0, wr_data0} !== 16'h3C9D) begin bad++; $display("FAIL ovr_next_cmd: got %0d writes %h expected 1 write 3c9d", wr_n0 - w, {wr_addr0, wr_data0}); end
        total++; if ({q0(b), q0(b + 1)} !== 16'h4B0A) begin bad++; $display("FAIL ovr_next_tx: got %h expected 4b0a", {q0(b), q0(b + 1)}); end
    endtask

    task automatic test_done_collision();
        int b = txq0.size();
        int e = err_n0;
        int r = rd_n0;
        tx_auto0 = 1'b0;
        send_str(0, "W0102\n");
        wait_txdv0();
        @(negedge clk); force_done0 = 1'b1;
        @(negedge clk); force_done0 = 1'b0;
        wait_txdv0();
        total++; if (g0(b + 1) != 1) begin bad++; $display("FAIL coll_tx_gap: got %0d expected 1", g0(b + 1)); end
        @(negedge clk);
        force_done0 = 1'b1; bus0.i_rx_dv = 1'b1; bus0.i_rx_byte = 8'h52;
        #1;
        total++; if (bus0.o_overrun !== 1'b1) begin bad++; $display("FAIL coll_overrun: got %b expected 1", bus0.o_overrun); end
        @(negedge clk);
        force_done0 = 1'b0; bus0.i_rx_dv = 1'b0;
        #1;
        total++; if (bus0.o_busy !== 1'b0) begin bad++; $display("FAIL coll_busy_drop: got %b expected 0", bus0.o_busy); end
        tx_auto0 = 1'b1;
        // the dropped 'R' must not open a frame: "00\n" is then malformed
        send_str(0, "00\n");
        wait_quiet0();
        total++; if (err_n0 - e != 1 || rd_n0 != r) begin bad++; $display("FAIL coll_dropped_byte: got err=%0d rd=%0d expected err=1 rd=0", err_n0 - e, rd_n0 - r); end
        total++; if ({q0(b), q0(b + 1), q0(b + 2), q0(b + 3)} !== 32'h4B0A450A) begin bad++; $display("FAIL coll_tx: got %h expected 4b0a450a", {q0(b), q0(b + 1), q0(b + 2), q0(b + 3)}); end
    endtask

    task automatic test_wrack0();
        int w = wr_n1;
        int t = txdv_n1;
        int bz = busy_n1;
        send_str(1, "W0011\n");
        repeat (5) @(negedge clk);
        total++; if (wr_n1 - w != 1) begin bad++; $display("FAIL noack_wr: got %0d expected 1", wr_n1 - w); end
        total++; if ({wr_addr1, wr_data1} !== 16'h0011) begin bad++; $display("FAIL noack_addr_data: got %h expected 0011", {wr_addr1, wr_data1}); end
        total++; if (txdv_n1 != t) begin bad++; $display("FAIL noack_tx: got %0d expected 0", txdv_n1 - t); end
        total++; if (busy_n1 - bz != 1) begin bad++; $display("FAIL noack_busy: got %0d cycles expected 1", busy_n1 - bz); end
    endtask

    task automatic test_reset_mid();
        int b = txq0.size();
        tx_auto0 = 1'b0;
        send_str(0, "W4455\n");
        wait_txdv0();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        total++; if ({bus0.o_tx_dv, bus0.o_reg_wr, bus0.o_reg_rd, bus0.o_busy, bus0.o_err, bus0.o_overrun} !== 6'b0) begin bad++; $display("FAIL rstmid_ctrl: got %b expected 000000", {bus0.o_tx_dv, bus0.o_reg_wr, bus0.o_reg_rd, bus0.o_busy, bus0.o_err, bus0.o_overrun}); end
        total++; if ({bus0.o_tx_byte, bus0.o_reg_addr, bus0.o_reg_wdata} !== 24'h0) begin bad++; $display("FAIL rstmid_regs: got %h expected 000000", {bus0.o_tx_byte, bus0.o_reg_addr, bus0.o_reg_wdata}); end
        @(negedge clk); force_done0 = 1'b1;
        @(negedge clk); force_done0 = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (txq0.size() - b != 1) begin bad++; $display("FAIL rstmid_no_more_tx: got %0d bytes expected 1", txq0.size() - b); end
        tx_auto0 = 1'b1;
        rd_val0  = 8'hF0;
        b = txq0.size();
        send_str(0, "R00\n");
        wait_quiet0();
        total++; if (txq0.size() - b != 3 || {q0(b), q0(b + 1), q0(b + 2)} !== 24'h46300A) begin bad++; $display("FAIL rstmid_read_after: got %0d bytes %h expected 3 bytes 46300a", txq0.size() - b, {q0(b), q0(b + 1), q0(b + 2)}); end
    endtask

    initial begin
        test_reset();
        test_write_ack();
        test_read();
        test_malformed();
        test_overrun();
        test_done_collision();
        test_wrack0();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Command controller downstream of the UART receiver and upstream of the UART transmitter.
- Consumes received bytes (one-cycle valid strobe plus byte), frames ASCII hex commands, and issues single-cycle register read/write strobes on a simple register bus.
- Sequences the response bytes into the UART transmitter with a strobe/done handshake.
- Provides the register-access path for the board-level command interface.

Parameters:
- WR_ACK, 1: 1 = a successful write replies "K\n"; 0 = write sends no reply.
- RD_LATENCY, 1: cycles from the o_reg_rd pulse to the i_reg_rdata sample point. Legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- i_rx_dv  input  1  one-cycle pulse; i_rx_byte valid.
- i_rx_byte  input  8  received byte.
- o_tx_dv  output  1  one-cycle pulse; o_tx_byte is to be sent.
- o_tx_byte  output  8  byte to transmit; held stable until i_tx_done.
- i_tx_done  input  1  one-cycle pulse; transmitter finished the current byte.
- o_reg_wr  output  1  one-cycle write strobe.
- o_reg_rd  output  1  one-cycle read strobe.
- o_reg_addr  output  8  register address; held from strobe to end of command.
- o_reg_wdata  output  8  write data.
- i_reg_rdata  input  8  read data, sampled RD_LATENCY cycles after o_reg_rd.
- o_busy  output  1  high from EXEC until the last response byte is done.
- o_err  output  1  one-cycle pulse when a malformed command is rejected.
- o_overrun  output  1  one-cycle pulse when a received byte is dropped while busy.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state returns to IDLE and all outputs go to 0, including o_tx_byte, o_reg_addr and o_reg_wdata. Reset mid-response aborts transmission; no further o_tx_dv is issued.
- Frame formats (case-insensitive command letter and hex digits):
  - "W" AH AL DH DL LF
  - "R" AH AL LF
  - Hex digit set: 0-9, A-F, a-f.
  - CR (0x0D) is ignored in every receive state.
- State machine, advancing only on i_rx_dv:
  - IDLE: 'W'/'w' -> ADDR_HI with write flag set. 'R'/'r' -> ADDR_HI with write flag clear. LF -> stay (empty line). Any other byte -> FLUSH.
  - ADDR_HI -> ADDR_LO -> (write: DATA_HI -> DATA_LO ->) EOL. Each valid hex digit shifts into the address/data nibble.
  - In a digit state: a non-hex byte goes to FLUSH; LF goes directly to ERR_RESP (short frame).
  - EOL: LF -> EXEC. Any other byte -> FLUSH.
  - FLUSH: discards bytes until LF, then -> ERR_RESP.
- EXEC (one cycle):
  - Write: o_reg_wr = 1 with o_reg_addr/o_reg_wdata valid the same cycle. Response is "K\n" if WR_ACK = 1; otherwise go straight to IDLE.
  - Read: o_reg_rd = 1, then RD_WAIT counts RD_LATENCY cycles and captures i_reg_rdata. Response is two uppercase hex chars then LF (e.g. 0x3C -> "3C\n").
- ERR_RESP: o_err pulses one cycle; response is "E\n".
- Response sequencing:
  - Response buffer holds at most 3 bytes plus a count.
  - SEND pulses o_tx_dv for one cycle with byte[n], then TX_WAIT holds until i_tx_done.
  - The next o_tx_dv fires on the cycle after i_tx_done.
  - After the last done, o_busy drops and the state returns to IDLE the same cycle.
  - i_tx_done outside TX_WAIT is ignored.
- Busy window: o_busy = 1 in EXEC, RD_WAIT, ERR_RESP, SEND and TX_WAIT. Any i_rx_dv in these states is dropped and o_overrun pulses the same cycle. Parsing resumes in IDLE, so the remainder of a partially dropped frame is parsed as a new frame.
- Hex encode: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x37+n.
- Simultaneous events: i_rx_dv coincident with the final i_tx_done is dropped (still busy that cycle).
- Register strobes never overlap; one command is in flight at a time.

Test Plan:
- Write with ack: rx "W1A5F\n" -> o_reg_wr pulse, o_reg_addr = 0x1A, o_reg_wdata = 0x5F. TX sends 0x4B then 0x0A, each after the prior i_tx_done. o_busy drops after the second done.
- Read, RD_LATENCY = 3: rx "r0c\r\n" with i_reg_rdata = 0xA7 three cycles after o_reg_rd -> o_reg_addr = 0x0C; TX "A7\n" (0x41, 0x37, 0x0A).
- Malformed frames:
  - "W1G\n" -> FLUSH; on LF, o_err pulse and TX "E\n"; no o_reg_wr.
  - "R1\n" (short) -> o_err, TX "E\n".
  - "X\n" -> o_err, TX "E\n".
  - Lone "\n" -> no response.
- Overrun: send "R00\n", then inject a byte while in TX_WAIT -> o_overrun pulse; response still "xx\n"; the next full command parses correctly.
- WR_ACK = 0: "W0011\n" -> o_reg_wr pulse, no o_tx_dv; o_busy high exactly one cycle.
- Reset mid-response: assert rst after the first o_tx_dv of "K\n" -> all outputs 0 next cycle; no second o_tx_dv even if i_tx_done arrives; the following "R00\n" works normally.
